sevenseg_scan_ctrl: RTL and testbench

//  Parametrised multiplexed seven-segment scanner. It supersedes the fixed 8-digit anode rotator clocked by a divided clock.
//  - Runs on the system clock with an internal clock-enable prescaler.
//  - Generalised digit count, tear-free frame-synchronous value loading, per-digit decimal points, PWM brightness.
//  - Sits between the debug/MMIO display mux and the board an/sev_out pins.

---
 rtl/sevenseg_scan_ctrl_pkg.sv | 26 ++
 rtl/sevenseg_scan_ctrl_if.sv | 20 ++
 rtl/sevenseg_scan_ctrl_scan_tick_gen.sv | 18 +
 rtl/sevenseg_scan_ctrl.sv | 84 ++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/sevenseg_scan_ctrl_pkg.sv
// sevenseg_pkg: segment type, blank pattern and hex decoder for the seven-segment scanner.
package sevenseg_pkg;
    typedef logic [6:0] seg_t;
    localparam seg_t SEG_BLANK = 7'h7F;
    // active-low {a..g}, a in the MSB
    function automatic seg_t hex2seg(input logic [3:0] h);
        case (h)
            4'h0: hex2seg = 7'b0000001;
            4'h1: hex2seg = 7'b1001111;
            4'h2: hex2seg = 7'b0010010;
            4'h3: hex2seg = 7'b0000110;
            4'h4: hex2seg = 7'b1001100;
            4'h5: hex2seg = 7'b0100100;
            4'h6: hex2seg = 7'b0100000;
            4'h7: hex2seg = 7'b0001111;
            4'h8: hex2seg = 7'b0000000;
            4'h9: hex2seg = 7'b0000100;
            4'hA: hex2seg = 7'b0001000;
            4'hB: hex2seg = 7'b1100000;
            4'hC: hex2seg = 7'b0110001;
            4'hD: hex2seg = 7'b1000010;
            4'hE: hex2seg = 7'b0110000;
            default: hex2seg = 7'b0111000;
        endcase
    endfunction
endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// sevenseg_scan_ctrl_if: display-value load side and board pin side of the scanner.
interface sevenseg_scan_ctrl_if #(
    parameter int DIGITS   = 8,
    parameter int BRIGHT_W = 4
);
    import sevenseg_pkg::*;
    logic [4*DIGITS-1:0] value_i;
    logic                value_valid;
    logic [DIGITS-1:0]   dp_i;
    logic                blank_i;
    logic [BRIGHT_W-1:0] brightness;
    logic [DIGITS-1:0]   an;
    seg_t                sev_out;
    logic                dp_out;
    logic                frame_done;
    modport master (output value_i, value_valid, dp_i, blank_i, brightness,
                    input  an, sev_out, dp_out, frame_done);
    modport slave  (input  value_i, value_valid, dp_i, blank_i, brightness,
                    output an, sev_out, dp_out, frame_done);
endinterface

// File: rtl/sevenseg_scan_ctrl_scan_tick_gen.sv
// scan_tick_gen: digit-slot prescaler; tick_o on the last cycle of a slot, first_o on its first.
module scan_tick_gen #(
    parameter int SCAN_DIV = 6250
) (
    input  logic clk,
    input  logic Rst,
    output logic tick_o,
    output logic first_o
);
    localparam int PW = $clog2(SCAN_DIV);
    logic [PW-1:0] presc_q, presc_d;
    assign tick_o  = presc_q == PW'(SCAN_DIV - 1);
    assign first_o = presc_q == '0;
    always_comb presc_d = tick_o ? '0 : presc_q + 1'b1;
    always_ff @(posedge clk or negedge Rst)
        if (!Rst) presc_q <= '0;
        else      presc_q <= presc_d;
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed seven-segment scanner with frame-synchronous loading and PWM dimming.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 6250,
    parameter int BRIGHT_W = 4
) (
    input logic clk,
    input logic Rst,
    sevenseg_scan_ctrl_if.slave bus
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    logic                tick, first, boundary, lit, lz;
    logic [IW-1:0]       idx_q, idx_d;
    logic [BRIGHT_W-1:0] pwm_q, pwm_d;
    logic [4*DIGITS-1:0] stage_q, stage_d, shadow_q, shadow_d;
    logic [DIGITS-1:0]   stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d, an_q, an_d;
    logic                pending_q, pending_d, dp_q, dp_d;
    seg_t                sev_q, sev_d;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk(clk), .Rst(Rst), .tick_o(tick), .first_o(first)
    );

    assign boundary = tick && idx_q == IW'(DIGITS - 1);
    assign lit      = ~bus.blank_i & ((bus.brightness == '1) | (pwm_q < bus.brightness));

    always_comb begin
        lz = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lz = idx_q != '0;
        for (int j = 0; j < DIGITS; j++)
            if (IW'(j) >= idx_q) lz = lz & (shadow_q[4*j +: 4] == 4'h0) & ~shadow_dp_q[j];
`endif
    end

    // a strobe on the boundary cycle flows through stage_d straight into the shadow
    always_comb begin
        idx_d       = tick ? (boundary ? '0 : idx_q + 1'b1) : idx_q;
        pwm_d       = pwm_q + 1'b1;
        stage_d     = bus.value_valid ? bus.value_i : stage_q;
        stage_dp_d  = bus.value_valid ? bus.dp_i : stage_dp_q;
        pending_d   = ~boundary & (bus.value_valid | pending_q);
        shadow_d    = boundary & (bus.value_valid | pending_q) ? stage_d : shadow_q;
        shadow_dp_d = boundary & (bus.value_valid | pending_q) ? stage_dp_d : shadow_dp_q;
        an_d        = '1;
        an_d[idx_q] = ~(lit & ~first);
        sev_d       = lz ? SEG_BLANK : hex2seg(shadow_q[4*idx_q +: 4]);
        dp_d        = ~shadow_dp_q[idx_q];
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            idx_q       <= '0;
            pwm_q       <= '0;
            stage_q     <= '0;
            stage_dp_q  <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pending_q   <= 1'b0;
            an_q        <= '1;
            sev_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            idx_q       <= idx_d;
            pwm_q       <= pwm_d;
            stage_q     <= stage_d;
            stage_dp_q  <= stage_dp_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pending_q   <= pending_d;
            an_q        <= an_d;
            sev_q       <= sev_d;
            dp_q        <= dp_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.sev_out    = sev_q;
    assign bus.dp_out     = dp_q;
    assign bus.frame_done = boundary;
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: randomized scoreboard bench; reference model derives slot/phase from cycle count.
module tb_sevenseg_scan_ctrl;
    localparam int DIG = 4;
    localparam int SD  = 4;
    localparam int BW  = 2;
    localparam int FR  = DIG * SD;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] sev;
        logic       dp;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic Rst = 1'b0;
    always #5 clk = ~clk;

    sevenseg_scan_ctrl_if #(.DIGITS(DIG), .BRIGHT_W(BW)) bus ();
    sevenseg_scan_ctrl #(.DIGITS(DIG), .SCAN_DIV(SD), .BRIGHT_W(BW)) dut (
        .clk(clk), .Rst(Rst), .bus(bus)
    );

    logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    exp_t        q[$];
    exp_t        e_mon;
    int          t;
    logic [15:0] shadow_m, last_m;
    logic [3:0]  sdp_m, ldp_m;
    bit          new_m;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: slot, prescaler phase and pwm phase all follow from cycles since reset
    always @(posedge clk or negedge Rst) begin : model
        int   slot, ph;
        bit   lit, lzb;
        exp_t e;
        if (!Rst) begin
            t        = 0;
            shadow_m = '0;
            sdp_m    = '0;
            new_m    = 0;
            q.delete();
        end else begin
            slot = (t / SD) % DIG;
            ph   = t % (1 << BW);
            lit  = !bus.blank_i && (int'(bus.brightness) == (1 << BW) - 1 || ph < int'(bus.brightness))
                   && (t % SD != 0);
            lzb  = 0;
`ifdef LEADING_ZERO_BLANK_EN
            lzb  = slot > 0 && (shadow_m >> (4 * slot)) == 16'h0 && (sdp_m >> slot) == 4'h0;
`endif
            e.an  = lit ? ~(4'b1 << slot) : 4'hF;
            e.sev = lzb ? 7'h7F : seg_tab[shadow_m[4*slot +: 4]];
            e.dp  = !sdp_m[slot];
            e.fd  = ((t + 1) % FR) == FR - 1;
            q.push_back(e);
            if (bus.value_valid) begin
                last_m = bus.value_i;
                ldp_m  = bus.dp_i;
                new_m  = 1;
            end
            if (t % FR == FR - 1 && new_m) begin
                shadow_m = last_m;
                sdp_m    = ldp_m;
                new_m    = 0;
            end
            t++;
        end
    end

    always @(negedge clk) begin
        if (q.size() != 0) begin
            e_mon = q.pop_front();
            check("an", 32'(bus.an), 32'(e_mon.an));
            check("sev_out", 32'(bus.sev_out), 32'(e_mon.sev));
            check("dp_out", 32'(bus.dp_out), 32'(e_mon.dp));
            check("frame_done", 32'(bus.frame_done), 32'(e_mon.fd));
        end else if (!Rst) begin
            check("rst_an", 32'(bus.an), 32'hF);
            check("rst_sev_out", 32'(bus.sev_out), 32'h7F);
            check("rst_dp_out", 32'(bus.dp_out), 32'h1);
            check("rst_frame_done", 32'(bus.frame_done), 32'h0);
        end
    end

    task automatic strobe(input logic [15:0] v, input logic [3:0] d);
        bus.value_i     = v;
        bus.dp_i        = d;
        bus.value_valid = 1'b1;
        @(negedge clk);
        bus.value_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 4 * FR && t % FR != p; i++) @(negedge clk);
        check("wait_frame_pos", 32'(t % FR), 32'(p));
    endtask

    initial begin
        bus.value_i     = '0;
        bus.value_valid = 1'b0;
        bus.dp_i        = '0;
        bus.blank_i     = 1'b0;
        bus.brightness  = 2'd3;
        cycles(3);
        Rst = 1'b1;
        strobe(16'h1234, 4'h0);
        cycles(40);
        wait_pos(5);
        strobe(16'hAAAA, 4'h0);
        cycles(4);
        strobe(16'h5555, 4'h2);
        cycles(40);
        wait_pos(FR - 1);
        strobe(16'hBEEF, 4'b0101);
        cycles(20);
        bus.brightness = 2'd1;
        cycles(32);
        bus.brightness = 2'd2;
        cycles(32);
        bus.brightness = 2'd0;
        cycles(20);
        bus.brightness = 2'd3;
        bus.blank_i    = 1'b1;
        cycles(20);
        bus.blank_i = 1'b0;
        strobe(16'h0040, 4'h0);
        cycles(40);
        strobe(16'h0040, 4'b1000);
        cycles(40);
        wait_pos(6);
        @(posedge clk);
        #2 Rst = 1'b0;
        #1;
        check("async_an", 32'(bus.an), 32'hF);
        check("async_sev_out", 32'(bus.sev_out), 32'h7F);
        check("async_dp_out", 32'(bus.dp_out), 32'h1);
        cycles(2);
        Rst = 1'b1;
        cycles(40);
        repeat (400) begin
            bus.value_valid = $urandom_range(0, 7) == 0;
            bus.value_i     = 16'($urandom) >> (4 * $urandom_range(0, 4));
            bus.dp_i        = $urandom_range(0, 3) == 0 ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            bus.brightness  = 2'($urandom);
            bus.blank_i     = $urandom_range(0, 15) == 0;
            @(negedge clk);
        end
        bus.value_valid = 1'b0;
        cycles(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
